// File: rtl/traffic_gen_pkg.sv
// Shared configuration for the mesh traffic generator: packet layout, mode
// encodings, mesh defaults and small arithmetic helpers.
package traffic_gen_pkg;

    localparam int unsigned X_NODES_DEF = 4;
    localparam int unsigned Y_NODES_DEF = 4;
    localparam int unsigned COORD_W     = 8;
    localparam int unsigned MEM_W       = 16;

    // Galois mask for x^32 + x^22 + x^2 + x + 1 in right-shift form.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_BERNOULLI = 2'b00,
        MODE_BURSTY    = 2'b01,
        MODE_ANTS      = 2'b10,
        MODE_IDLE      = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_st_e;

    typedef struct packed {
        logic               ant;
        logic               backward;
        logic [3:0]         num_memories;
        logic [MEM_W-1:0]   memories;
        logic [COORD_W-1:0] src_x;
        logic [COORD_W-1:0] src_y;
        logic [COORD_W-1:0] dst_x;
        logic [COORD_W-1:0] dst_y;
    } packet_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // A zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] node_seed(input logic [31:0] seed, input int unsigned n);
        logic [31:0] s;
        s = seed ^ n[31:0];
        return (s == 32'h0000_0000) ? 32'h0000_0001 : s;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic packet_t idle_packet(input logic [COORD_W-1:0] sx,
                                            input logic [COORD_W-1:0] sy);
        packet_t p;
        p       = '0;
        p.src_x = sx;
        p.src_y = sy;
        return p;
    endfunction

endpackage

// File: rtl/traffic_gen_fifo.sv
// Per-node packet queue; a pop frees a slot for a push in the same cycle.
module fifo_packet
    import traffic_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 8
)
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push_i,
    input  packet_t wdata_i,
    input  logic    pop_i,
    output packet_t rdata_o,
    output logic    empty_o,
    output logic    full_o
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned DEPTH_U = DEPTH;

    packet_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_pop_s;
    logic          do_push_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == DEPTH_U[AW:0]);
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap on the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + {{AW{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{AW{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is left unreset; the head is masked by empty_o downstream.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/traffic_gen_node.sv
// One mesh node's packet source: free-running LFSR, bursty FSM and packet
// assembly. Generation is combinational so the queue captures it this cycle.
module tg_node
    import traffic_gen_pkg::*;
#(
    parameter int unsigned X_NODES     = X_NODES_DEF,
    parameter int unsigned Y_NODES     = Y_NODES_DEF,
    parameter logic [7:0]  RATE_THRESH = 8'd5,
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned NODE_ID     = 0,
    parameter logic [31:0] SEED        = 32'h0000_ACE1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_i,
    input  logic [1:0] mode_i,
    input  logic       ant_i,
    output logic       gen_o,
    output packet_t    pkt_o
);
    localparam logic [31:0]        NODE_SEED  = node_seed(SEED, NODE_ID);
    localparam logic [7:0]         X_MOD      = 8'(X_NODES);
    localparam logic [7:0]         Y_MOD      = 8'(Y_NODES);
    localparam logic [COORD_W-1:0] SRC_X      = COORD_W'(NODE_ID % X_NODES);
    localparam logic [COORD_W-1:0] SRC_Y      = COORD_W'(NODE_ID / X_NODES);
    localparam logic [7:0]         BURST_LAST = 8'(BURST_LEN - 1);

    logic [31:0]        lfsr_q;
    burst_st_e          state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [COORD_W-1:0] bdx_q, bdx_d;
    logic [COORD_W-1:0] bdy_q, bdy_d;
    logic [COORD_W-1:0] rnd_dx_s, rnd_dy_s;
    logic               hit_s;
    logic               data_gen_s;
    logic               use_burst_s;
    mode_e              mode_s;
    logic               unused_s;

    assign mode_s   = mode_e'(mode_i);
    assign hit_s    = (lfsr_q[7:0] < RATE_THRESH);
    assign rnd_dx_s = lfsr_q[15:8] % X_MOD;
    assign rnd_dy_s = lfsr_q[23:16] % Y_MOD;
    assign unused_s = ^lfsr_q[31:24];

    // LFSR advances every cycle; FSM and latched burst destination update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q  <= NODE_SEED;
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            bdx_q   <= '0;
            bdy_q   <= '0;
        end else begin
            lfsr_q  <= lfsr_next(lfsr_q);
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bdx_q   <= bdx_d;
            bdy_q   <= bdy_d;
        end
    end

    // The trigger cycle only latches the destination; BURST emits BURST_LEN
    // packets. Dropping run or leaving bursty mode aborts immediately.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bdx_d       = bdx_q;
        bdy_d       = bdy_q;
        data_gen_s  = 1'b0;
        use_burst_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_i && (mode_s == MODE_BERNOULLI)) begin
                    data_gen_s = hit_s;
                end else if (run_i && (mode_s == MODE_BURSTY) && hit_s) begin
                    state_d = ST_BURST;
                    cnt_d   = 8'd0;
                    bdx_d   = rnd_dx_s;
                    bdy_d   = rnd_dy_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (run_i && (mode_s == MODE_BURSTY)) begin
                    data_gen_s  = 1'b1;
                    use_burst_s = 1'b1;
                    if (cnt_q == BURST_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Ants override the data flag but keep the burst destination if bursting.
    always_comb begin
        pkt_o       = idle_packet(SRC_X, SRC_Y);
        pkt_o.ant   = ant_i;
        pkt_o.dst_x = use_burst_s ? bdx_q : rnd_dx_s;
        pkt_o.dst_y = use_burst_s ? bdy_q : rnd_dy_s;
        gen_o       = ant_i || data_gen_s;
    end

endmodule

// File: rtl/traffic_gen.sv
// Synthetic mesh traffic source: NODES generators with private queues,
// periodic ant injection, and saturating traffic statistics.
module traffic_gen
    import traffic_gen_pkg::*;
#(
    parameter int unsigned X_NODES     = X_NODES_DEF,
    parameter int unsigned Y_NODES     = Y_NODES_DEF,
    parameter logic [7:0]  RATE_THRESH = 8'd5,
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned ANT_PERIOD  = 1000,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter logic [31:0] SEED        = 32'h0000_ACE1
)
(
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 i_run,
    input  logic [1:0]                           i_mode,
    input  logic [X_NODES*Y_NODES-1:0]           i_en,
    output packet_t [X_NODES*Y_NODES-1:0]        o_data,
    output logic [X_NODES*Y_NODES-1:0]           o_data_val,
    output logic [31:0]                          o_gen_count,
    output logic [31:0]                          o_sent_count,
    output logic [31:0]                          o_drop_count,
    output logic [63:0]                          o_time
);
    localparam int unsigned NODES    = X_NODES * Y_NODES;
    localparam int unsigned CNT_W    = $clog2(NODES + 1);
    localparam logic [31:0] ANT_LAST = (ANT_PERIOD == 0) ? 32'd0 : 32'(ANT_PERIOD - 1);

    logic [NODES-1:0]    gen_s, pop_s, drop_s, empty_s, full_s;
    packet_t [NODES-1:0] pkt_s, head_s;
    logic [31:0]         ant_cnt_q;
    logic                ant_s;
    logic [CNT_W-1:0]    gen_sum_s, sent_sum_s, drop_sum_s;
    logic [31:0]         gen_cnt_q, sent_cnt_q, drop_cnt_q;
    logic [63:0]         time_q;

    // ant_cnt_q tracks o_time modulo ANT_PERIOD without a wide divider.
    assign ant_s = (ANT_PERIOD != 0) && (ant_cnt_q == 32'd0) && i_run
                   && (mode_e'(i_mode) != MODE_IDLE);

    for (genvar n = 0; n < NODES; n++) begin : g_node
        localparam logic [COORD_W-1:0] SX = COORD_W'(n % X_NODES);
        localparam logic [COORD_W-1:0] SY = COORD_W'(n / X_NODES);

        tg_node #(
            .X_NODES     (X_NODES),
            .Y_NODES     (Y_NODES),
            .RATE_THRESH (RATE_THRESH),
            .BURST_LEN   (BURST_LEN),
            .NODE_ID     (n),
            .SEED        (SEED)
        ) u_node (
            .clk     (clk),
            .reset_n (reset_n),
            .run_i   (i_run),
            .mode_i  (i_mode),
            .ant_i   (ant_s),
            .gen_o   (gen_s[n]),
            .pkt_o   (pkt_s[n])
        );

        fifo_packet #(
            .DEPTH (QUEUE_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push_i  (gen_s[n]),
            .wdata_i (pkt_s[n]),
            .pop_i   (pop_s[n]),
            .rdata_o (head_s[n]),
            .empty_o (empty_s[n]),
            .full_o  (full_s[n])
        );

        assign pop_s[n]      = !empty_s[n] && i_en[n];
        assign drop_s[n]     = gen_s[n] && full_s[n] && !pop_s[n];
        assign o_data_val[n] = !empty_s[n];
        assign o_data[n]     = empty_s[n] ? idle_packet(SX, SY) : head_s[n];
    end

    // Per-cycle event totals across all nodes.
    always_comb begin
        gen_sum_s  = '0;
        sent_sum_s = '0;
        drop_sum_s = '0;
        for (int n = 0; n < NODES; n++) begin
            gen_sum_s  = gen_sum_s  + CNT_W'(gen_s[n]);
            sent_sum_s = sent_sum_s + CNT_W'(pop_s[n]);
            drop_sum_s = drop_sum_s + CNT_W'(drop_s[n]);
        end
    end

    // Cycle counter, ant phase and saturating statistics.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            time_q     <= 64'd0;
            ant_cnt_q  <= 32'd0;
            gen_cnt_q  <= 32'd0;
            sent_cnt_q <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            time_q     <= time_q + 64'd1;
            ant_cnt_q  <= (ant_cnt_q >= ANT_LAST) ? 32'd0 : ant_cnt_q + 32'd1;
            gen_cnt_q  <= sat_add(gen_cnt_q,  32'(gen_sum_s));
            sent_cnt_q <= sat_add(sent_cnt_q, 32'(sent_sum_s));
            drop_cnt_q <= sat_add(drop_cnt_q, 32'(drop_sum_s));
        end
    end

    assign o_time       = time_q;
    assign o_gen_count  = gen_cnt_q;
    assign o_sent_count = sent_cnt_q;
    assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_traffic_gen.sv
// Bench for traffic_gen: phase table plus hand sequences, checked every cycle
// against a per-node reference model and a queue scoreboard.
module tb_traffic_gen;
    import traffic_gen_pkg::*;

    localparam int unsigned X      = 2;
    localparam int unsigned Y      = 2;
    localparam int unsigned NODES  = X * Y;
    localparam logic [7:0]  RATE   = 8'd255;
    localparam int unsigned BURST  = 4;
    localparam int unsigned ANT_P  = 100;
    localparam int unsigned DEPTH  = 8;
    localparam logic [31:0] SEED_V = 32'h0000_ACE1;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                i_run = 1'b0;
    logic [1:0]          i_mode = 2'b00;
    logic [NODES-1:0]    i_en = '0;
    packet_t [NODES-1:0] o_data, b_data;
    logic [NODES-1:0]    o_data_val, b_data_val;
    logic [31:0]         o_gen_count, o_sent_count, o_drop_count;
    logic [31:0]         b_gen_count, b_sent_count, b_drop_count;
    logic [63:0]         o_time, b_time;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    traffic_gen #(.X_NODES(X), .Y_NODES(Y), .RATE_THRESH(RATE), .BURST_LEN(BURST),
                  .ANT_PERIOD(ANT_P), .QUEUE_DEPTH(DEPTH), .SEED(SEED_V)) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_mode(i_mode), .i_en(i_en),
        .o_data(o_data), .o_data_val(o_data_val), .o_gen_count(o_gen_count),
        .o_sent_count(o_sent_count), .o_drop_count(o_drop_count), .o_time(o_time));

    // Silent configuration: zero rate and no ants must never produce anything.
    traffic_gen #(.X_NODES(X), .Y_NODES(Y), .RATE_THRESH(8'd0), .BURST_LEN(BURST),
                  .ANT_PERIOD(0), .QUEUE_DEPTH(DEPTH), .SEED(SEED_V)) dut_zero (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_mode(i_mode), .i_en(i_en),
        .o_data(b_data), .o_data_val(b_data_val), .o_gen_count(b_gen_count),
        .o_sent_count(b_sent_count), .o_drop_count(b_drop_count), .o_time(b_time));

    // Reference model state
    logic [31:0]        m_lfsr [NODES];
    bit                 m_burst [NODES];
    int                 m_cnt [NODES];
    logic [7:0]         m_dx [NODES];
    logic [7:0]         m_dy [NODES];
    packet_t            sb [NODES][$];
    longint unsigned    m_gen, m_sent, m_drop, m_time;

    typedef struct {
        bit         rst;
        bit         run;
        bit [1:0]   mode;
        bit [3:0]   en;
        int         cycles;
        int         exp_gen;
        int         exp_sent;
        int         exp_drop;
    } phase_t;

    phase_t ph [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_adv(input logic [31:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
        return s;
    endfunction

    function automatic packet_t src_pkt(input int n);
        packet_t p;
        p = '0;
        p.src_x = 8'(n % X);
        p.src_y = 8'(n / X);
        return p;
    endfunction

    task automatic model_reset();
        logic [31:0] s;
        for (int n = 0; n < NODES; n++) begin
            s = SEED_V ^ 32'(n);
            m_lfsr[n]  = (s == 32'h0) ? 32'h1 : s;
            m_burst[n] = 1'b0;
            m_cnt[n]   = 0;
            m_dx[n]    = 8'd0;
            m_dy[n]    = 8'd0;
            sb[n].delete();
        end
        m_gen = 0; m_sent = 0; m_drop = 0; m_time = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // Compare current outputs, advance the model by one cycle, then clock.
    task automatic step();
        bit ant, pop, hit, gen, bd;
        packet_t p;
        for (int n = 0; n < NODES; n++) begin
            chk("data_val", 64'(o_data_val[n]), 64'(sb[n].size() != 0));
            if (sb[n].size() != 0) chk("data_head", 64'(o_data[n]), 64'(sb[n][0]));
            else chk("idle_data", 64'(o_data[n]), 64'(src_pkt(n)));
        end
        chk("gen_count", 64'(o_gen_count), m_gen);
        chk("sent_count", 64'(o_sent_count), m_sent);
        chk("drop_count", 64'(o_drop_count), m_drop);
        chk("time", o_time, m_time);
        chk("zero_val", 64'(b_data_val), 64'd0);
        chk("zero_gen", 64'(b_gen_count), 64'd0);

        ant = i_run && (i_mode != 2'b11) && ((m_time % ANT_P) == 0);
        for (int n = 0; n < NODES; n++) begin
            pop = (sb[n].size() != 0) && i_en[n];
            hit = m_lfsr[n][7:0] < RATE;
            gen = 1'b0;
            bd  = 1'b0;
            if (m_burst[n]) begin
                if (i_run && i_mode == 2'b01) begin
                    gen = 1'b1;
                    bd  = 1'b1;
                    if (m_cnt[n] == BURST - 1) begin m_burst[n] = 1'b0; m_cnt[n] = 0; end
                    else m_cnt[n]++;
                end else begin
                    m_burst[n] = 1'b0;
                    m_cnt[n]   = 0;
                end
            end else if (i_run && i_mode == 2'b00) begin
                gen = hit;
            end else if (i_run && i_mode == 2'b01 && hit) begin
                m_burst[n] = 1'b1;
                m_cnt[n]   = 0;
                m_dx[n]    = m_lfsr[n][15:8] % 8'(X);
                m_dy[n]    = m_lfsr[n][23:16] % 8'(Y);
            end
            gen = gen || ant;
            p = src_pkt(n);
            p.ant   = ant;
            p.dst_x = bd ? m_dx[n] : (m_lfsr[n][15:8] % 8'(X));
            p.dst_y = bd ? m_dy[n] : (m_lfsr[n][23:16] % 8'(Y));
            if (pop) begin
                void'(sb[n].pop_front());
                m_sent++;
            end
            if (gen) begin
                m_gen++;
                if (sb[n].size() < DEPTH) sb[n].push_back(p);
                else m_drop++;
            end
            m_lfsr[n] = m_adv(m_lfsr[n]);
        end
        m_time++;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] g0, s0, d0;
        bit found;

        ph[0] = '{1'b1, 1'b1, 2'b00, 4'hF, 1000, -1, -1, -1};
        ph[1] = '{1'b1, 1'b1, 2'b00, 4'h0,   20, -1,  0, -1};
        ph[2] = '{1'b0, 1'b1, 2'b00, 4'hF,   30, -1, -1,  0};
        ph[3] = '{1'b1, 1'b1, 2'b10, 4'hF, 1000, 40, 40,  0};
        ph[4] = '{1'b1, 1'b1, 2'b01, 4'hF,  200, -1, -1, -1};
        ph[5] = '{1'b0, 1'b1, 2'b11, 4'hF,   50,  0, -1,  0};
        ph[6] = '{1'b0, 1'b0, 2'b00, 4'hF,   50,  0, -1,  0};

        @(posedge clk); #1;
        do_reset();
        chk("reset_val", 64'(o_data_val), 64'd0);
        chk("reset_time", o_time, 64'd0);
        chk("reset_gen", 64'(o_gen_count), 64'd0);

        for (int i = 0; i < 7; i++) begin
            if (ph[i].rst) do_reset();
            i_run  = ph[i].run;
            i_mode = ph[i].mode;
            i_en   = ph[i].en;
            g0 = o_gen_count; s0 = o_sent_count; d0 = o_drop_count;
            repeat (ph[i].cycles) step();
            if (ph[i].exp_gen >= 0)  chk("phase_gen",  64'(o_gen_count - g0),  64'(ph[i].exp_gen));
            if (ph[i].exp_sent >= 0) chk("phase_sent", 64'(o_sent_count - s0), 64'(ph[i].exp_sent));
            if (ph[i].exp_drop >= 0) chk("phase_drop", 64'(o_drop_count - d0), 64'(ph[i].exp_drop));
            if (i == 1) begin
                chk("full_val", 64'(o_data_val), 64'hF);
                chk("drop_vs_gen", 64'(o_drop_count), m_gen - 64'(DEPTH * NODES));
            end
        end

        // Burst aborted after two packets when run drops.
        do_reset();
        i_run = 1'b1; i_mode = 2'b01; i_en = 4'hF;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            step();
            if (m_burst[0] && m_cnt[0] == 2) found = 1'b1;
        end
        chk("burst_reached", 64'(found), 64'd1);
        g0 = o_gen_count;
        i_run = 1'b0;
        repeat (6) step();
        chk("abort_gen", 64'(o_gen_count - g0), 64'd0);

        // Reset with full queues discards everything and replays the seeds.
        do_reset();
        i_run = 1'b1; i_mode = 2'b00; i_en = 4'h0;
        repeat (12) step();
        chk("prefill_val", 64'(o_data_val), 64'hF);
        do_reset();
        i_en = 4'hF;
        chk("rst_val", 64'(o_data_val), 64'd0);
        chk("rst_sent", 64'(o_sent_count), 64'd0);
        chk("rst_drop", 64'(o_drop_count), 64'd0);
        chk("rst_gen", 64'(o_gen_count), 64'd0);
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_gen.md
TRAFFIC_GEN -- requirements
Module: traffic_gen

Interface
REQ-001 Parameter X_NODES, default 4: mesh columns.
REQ-002 Parameter Y_NODES, default 4: mesh rows; NODES = X_NODES*Y_NODES.
REQ-003 Parameter RATE_THRESH, default 5 (8 bits): a node offers a packet when its 8-bit LFSR sample < RATE_THRESH.
REQ-004 Parameter BURST_LEN, default 4: packets per burst in bursty mode (1..255).
REQ-005 Parameter ANT_PERIOD, default 1000: cycles between ant injections; 0 disables ants.
REQ-006 Parameter QUEUE_DEPTH, default 8: per-node packet queue depth (power of 2, >=2).
REQ-007 Parameter SEED, default 32'hACE1: LFSR base seed; node n is seeded with SEED^n, never zero.
REQ-008 Port: clk  in  1  rising-edge clock.
REQ-009 Port: reset_n  in  1  reset, synchronous, active-low.
REQ-010 Port: i_run  in  1  generation enable; queues keep draining when low.
REQ-011 Port: i_mode  in  2  00 Bernoulli, 01 bursty, 10 ants only, 11 idle.
REQ-012 Port: i_en  in  NODES  network ready per node.
REQ-013 Port: o_data  out  NODES x packet_t  head-of-queue packet per node.
REQ-014 Port: o_data_val  out  NODES  head valid per node.
REQ-015 Port: o_gen_count, o_sent_count, o_drop_count  out  32 each  totals over all nodes.
REQ-016 Port: o_time  out  64  cycle counter.

Function
REQ-017 o_time increments by 1 every cycle after reset.
REQ-018 Each node advances a 32-bit Galois LFSR (taps 32,22,2,1) every cycle.
REQ-019 Destinations: x_dest = LFSR[15:8] mod X_NODES, y_dest = LFSR[23:16] mod Y_NODES; self-destination allowed.
REQ-020 Source fields hold the node's own x,y; memory fields and num_memories are zero; backward = 0.
REQ-021 Bernoulli: a data packet (ant=0) is generated when i_run=1 and LFSR[7:0] < RATE_THRESH.
REQ-022 Bursty, per-node FSM IDLE->BURST when the Bernoulli test passes; BURST generates one packet per cycle for BURST_LEN cycles, then returns to IDLE; all packets of a burst share one destination.
REQ-023 Ant: when ANT_PERIOD != 0, i_run=1, mode != 11 and o_time % ANT_PERIOD == 0, every node generates one packet with ant=1 that cycle, taking precedence over a data packet.
REQ-024 A packet generated in cycle t is written to the queue at the end of t and is visible on o_data/o_data_val at t+1 at the earliest.
REQ-025 Handshake: a transfer occurs when o_data_val && i_en; the head is popped in the same cycle, and o_data is stable while o_data_val=1 and i_en=0.
REQ-026 Queue full with no pop: the generated packet is dropped and o_drop_count increments; the bursty FSM still advances.
REQ-027 Queue full with a simultaneous pop: the push is accepted and nothing is dropped.
REQ-028 Counters: o_gen_count counts generated packets (including dropped), o_sent_count counts transfers, o_drop_count counts drops; multiple nodes in one cycle add their sum; all saturate at 2^32-1.
REQ-029 i_run falling mid-burst forces the FSM to IDLE next cycle with no further packets.
REQ-030 Mode change takes effect the next cycle; a mode change during BURST aborts the burst.

Reset
REQ-031 While reset_n=0 at a rising edge: queues are emptied, o_data_val=0, o_data fields are 0 except source, FSMs are IDLE, counters and o_time are 0, and LFSRs are loaded with their seeds.
REQ-032 Reset mid-operation discards all queued packets; nothing is counted as sent or dropped.

Structure
REQ-033 packet_t, X_NODES/Y_NODES defaults and mode encodings live in the shared config package.
REQ-034 The per-node queue reuses the existing fifo_packet; one sub-module tg_node (LFSR, burst FSM, packet build) is instantiated NODES times.

Verification
REQ-035 RATE_THRESH=0, ANT_PERIOD=0, i_run=1, mode 00, i_en all 1, 1000 cycles -> o_gen_count=0, o_data_val never 1.
REQ-036 RATE_THRESH=255, i_en=0, QUEUE_DEPTH=8, 20 cycles -> each node holds 8 packets, o_drop_count = NODES*(generated-8), o_data stable.
REQ-037 ANT_PERIOD=100, mode 10, i_en=1, 1000 cycles -> o_sent_count = 10*NODES, every sent packet has ant=1.
REQ-038 Mode 01, BURST_LEN=4 -> packets on a node come in runs of 4 consecutive cycles with identical destination; i_run dropped after 2 packets -> no 3rd packet.
REQ-039 Queue full, i_en=1, generation every cycle -> o_drop_count unchanged, one push and one pop per cycle.
REQ-040 Assert reset_n=0 for 1 cycle with queues non-empty -> next cycle o_data_val=0, counters=0, and the LFSR sequence repeats the post-reset trace bit-exactly.
